// File: rtl/forward_scoreboard_pkg.sv
// Shared types and defaults for the forwarding scoreboard.
// Next-PC op encodings let the decoder derive id_is_branch consistently.
package forward_scoreboard_pkg;

    localparam int DEF_NUM_SRC = 2;
    localparam int DEF_DEPTH   = 2;
    localparam int DEF_REG_AW  = 5;

    // Per-stage producer flags; rd/rs widths depend on REG_AW so they live beside it.
    typedef struct packed {
        logic valid;
        logic regwrite;
        logic memread;
    } entry_t;

    typedef enum logic [1:0] {
        NPC_PLUS4  = 2'd0,
        NPC_BRANCH = 2'd1,
        NPC_JAL    = 2'd2,
        NPC_JALR   = 2'd3
    } npc_op_e;

    // Any redirecting op resolves in ID and therefore needs its operands there.
    function automatic logic npc_needs_id_operands(npc_op_e op);
        return op != NPC_PLUS4;
    endfunction

endpackage

// File: rtl/fwd_prio_match.sv
// One operand compared against stages 1..DEPTH: nearest forwardable stage
// (one-hot) plus the nearest match when it is a not-yet-forwardable load.
module fwd_prio_match #(
    parameter int DEPTH      = 2,
    parameter int LOAD_STAGE = 2,
    parameter int REG_AW     = 5
) (
    input  logic [REG_AW-1:0]       rs_i,
    input  logic [DEPTH-1:0]        valid_i,
    input  logic [DEPTH-1:0]        regwrite_i,
    input  logic [DEPTH-1:0]        memread_i,
    input  logic [DEPTH*REG_AW-1:0] rd_i,
    output logic [DEPTH-1:0]        sel_o,
    output logic [DEPTH-1:0]        load_oh_o,
    output logic                    load_hit_o
);
    logic [DEPTH-1:0] hit;
    logic [DEPTH-1:0] fwd_ok;
    logic             seen_hit;
    logic             seen_fwd;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            assign hit[gi] = valid_i[gi] && regwrite_i[gi]
                          && (rd_i[gi*REG_AW +: REG_AW] != '0)
                          && (rd_i[gi*REG_AW +: REG_AW] == rs_i);
            // bit gi is stage gi+1; loads there have no data before LOAD_STAGE
            assign fwd_ok[gi] = !(memread_i[gi] && (gi + 1 < LOAD_STAGE));
        end
    endgenerate

    always_comb begin
        sel_o     = '0;
        load_oh_o = '0;
        seen_hit  = 1'b0;
        seen_fwd  = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (hit[k] && !seen_hit && !fwd_ok[k]) begin
                load_oh_o[k] = 1'b1;
            end
            if (hit[k] && fwd_ok[k] && !seen_fwd) begin
                sel_o[k] = 1'b1;
            end
            seen_hit = seen_hit || hit[k];
            seen_fwd = seen_fwd || (hit[k] && fwd_ok[k]);
        end
    end

    assign load_hit_o = |load_oh_o;

endmodule

// File: rtl/forward_scoreboard.sv
// Tracks EX..WB producers, drives EX/ID forwarding selects and the ID hazard stall.
// Define FWD_ID_BRANCH_EN to forward into ID for branches instead of stalling them.
module forward_scoreboard
    import forward_scoreboard_pkg::*;
#(
    parameter int NUM_SRC    = DEF_NUM_SRC,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int LOAD_STAGE = DEPTH,
    parameter int REG_AW     = DEF_REG_AW
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_regwrite,
    input  logic                      id_memread,
    input  logic                      id_is_branch,
    input  logic                      pipe_freeze,
    input  logic                      flush_ex,
    output logic [NUM_SRC*DEPTH-1:0]  ex_fwd,
    output logic [NUM_SRC*DEPTH-1:0]  id_fwd,
    output logic                      hazard_stall
);
    entry_t                    ent_q [DEPTH+1];
    entry_t                    ent_d [DEPTH+1];
    logic [REG_AW-1:0]         rd_q  [DEPTH+1];
    logic [REG_AW-1:0]         rd_d  [DEPTH+1];
    logic [NUM_SRC*REG_AW-1:0] ex_rs_q;
    logic [NUM_SRC*REG_AW-1:0] ex_rs_d;

    logic [DEPTH-1:0]          old_valid;
    logic [DEPTH-1:0]          old_regwrite;
    logic [DEPTH-1:0]          old_memread;
    logic [DEPTH*REG_AW-1:0]   old_rd;
    logic [DEPTH-1:0]          lu_mask;
    logic [DEPTH-1:0]          pre_wb_mask;

    logic [NUM_SRC-1:0][DEPTH-1:0] ex_sel;
    logic [NUM_SRC-1:0][DEPTH-1:0] ex_load_oh;
    logic [NUM_SRC-1:0][DEPTH-1:0] id_sel;
    logic [NUM_SRC-1:0][DEPTH-1:0] id_load_oh;
    logic [NUM_SRC-1:0]            ex_load_hit;
    logic [NUM_SRC-1:0]            id_load_hit;
    logic [NUM_SRC-1:0]            e0_hit;
    logic [NUM_SRC-1:0]            ld_stall;
    logic [NUM_SRC-1:0]            op_stall;
    logic                          stall;
    logic                          unused_match_flags;

    genvar gi;
    generate
        for (gi = 1; gi <= DEPTH; gi++) begin : g_pack
            assign old_valid[gi-1]                  = ent_q[gi].valid;
            assign old_regwrite[gi-1]               = ent_q[gi].regwrite;
            assign old_memread[gi-1]                = ent_q[gi].memread;
            assign old_rd[(gi-1)*REG_AW +: REG_AW]  = rd_q[gi];
            // a load at stage gi blocks an ID consumer only if it still cannot forward next cycle
            assign lu_mask[gi-1]                    = (gi + 1 < LOAD_STAGE);
            assign pre_wb_mask[gi-1]                = (gi < DEPTH);
        end

        for (gi = 0; gi < NUM_SRC; gi++) begin : g_op
            logic [REG_AW-1:0] id_r;
            assign id_r = id_rs[gi*REG_AW +: REG_AW];

            fwd_prio_match #(
                .DEPTH      (DEPTH),
                .LOAD_STAGE (LOAD_STAGE),
                .REG_AW     (REG_AW)
            ) u_ex (
                .rs_i       (ex_rs_q[gi*REG_AW +: REG_AW]),
                .valid_i    (old_valid),
                .regwrite_i (old_regwrite),
                .memread_i  (old_memread),
                .rd_i       (old_rd),
                .sel_o      (ex_sel[gi]),
                .load_oh_o  (ex_load_oh[gi]),
                .load_hit_o (ex_load_hit[gi])
            );

            fwd_prio_match #(
                .DEPTH      (DEPTH),
                .LOAD_STAGE (LOAD_STAGE),
                .REG_AW     (REG_AW)
            ) u_id (
                .rs_i       (id_r),
                .valid_i    (old_valid),
                .regwrite_i (old_regwrite),
                .memread_i  (old_memread),
                .rd_i       (old_rd),
                .sel_o      (id_sel[gi]),
                .load_oh_o  (id_load_oh[gi]),
                .load_hit_o (id_load_hit[gi])
            );

            assign e0_hit[gi] = ent_q[0].valid && ent_q[0].regwrite
                             && (rd_q[0] != '0) && (rd_q[0] == id_r);

            // A match in EX is always the nearest, so it shadows any older load.
            assign ld_stall[gi] = e0_hit[gi] ? (ent_q[0].memread && (LOAD_STAGE > 1))
                                             : |(id_load_oh[gi] & lu_mask);
`ifdef FWD_ID_BRANCH_EN
            assign op_stall[gi] = ld_stall[gi]
                               || (id_is_branch && (e0_hit[gi] || id_load_hit[gi]));
            assign id_fwd[gi*DEPTH +: DEPTH] = (rstn && id_valid && id_is_branch)
                                             ? id_sel[gi] : '0;
`else
            // lowest set bit of sel|load_oh is the nearest match of any kind
            assign op_stall[gi] = ld_stall[gi]
                               || (id_is_branch && (e0_hit[gi]
                                   || |((id_sel[gi] | id_load_oh[gi]) & pre_wb_mask)));
            assign id_fwd[gi*DEPTH +: DEPTH] = '0;
`endif
            assign ex_fwd[gi*DEPTH +: DEPTH] = rstn ? ex_sel[gi] : '0;
        end
    endgenerate

    assign stall        = rstn && id_valid && (|op_stall);
    assign hazard_stall = stall;

    assign unused_match_flags = ^{ex_load_hit, ex_load_oh, id_load_hit};

    always_comb begin
        ent_d   = ent_q;
        rd_d    = rd_q;
        ex_rs_d = ex_rs_q;
        if (pipe_freeze) begin
            if (flush_ex) begin
                ent_d[0].valid = 1'b0;
            end
        end else begin
            for (int k = 1; k <= DEPTH; k++) begin
                ent_d[k] = ent_q[k-1];
                rd_d[k]  = rd_q[k-1];
            end
            if (id_valid && !stall && !flush_ex) begin
                ent_d[0] = '{valid: 1'b1, regwrite: id_regwrite, memread: id_memread};
                rd_d[0]  = id_rd;
                ex_rs_d  = id_rs;
            end else begin
                ent_d[0] = '0;
                rd_d[0]  = '0;
                ex_rs_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k <= DEPTH; k++) begin
                ent_q[k] <= '0;
                rd_q[k]  <= '0;
            end
            ex_rs_q <= '0;
        end else begin
            ent_q   <= ent_d;
            rd_q    <= rd_d;
            ex_rs_q <= ex_rs_d;
        end
    end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed scoreboard bench for forward_scoreboard (default parameters).
// Expectations adapt to FWD_ID_BRANCH_EN where branch behaviour differs.
module tb_forward_scoreboard;
    import forward_scoreboard_pkg::*;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       id_valid = 1'b0;
    logic [9:0] id_rs = '0;
    logic [4:0] id_rd = '0;
    logic       id_regwrite = 1'b0;
    logic       id_memread = 1'b0;
    logic       id_is_branch = 1'b0;
    logic       pipe_freeze = 1'b0;
    logic       flush_ex = 1'b0;
    logic [3:0] ex_fwd;
    logic [3:0] id_fwd;
    logic       hazard_stall;

    typedef struct {
        string      name;
        logic [3:0] ex;
        logic [3:0] id;
        logic       st;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    forward_scoreboard dut (
        .clk          (clk),
        .rstn         (rstn),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rd        (id_rd),
        .id_regwrite  (id_regwrite),
        .id_memread   (id_memread),
        .id_is_branch (id_is_branch),
        .pipe_freeze  (pipe_freeze),
        .flush_ex     (flush_ex),
        .ex_fwd       (ex_fwd),
        .id_fwd       (id_fwd),
        .hazard_stall (hazard_stall)
    );

    // Drive one cycle of ID-side inputs just after the edge and queue the expected outputs.
    task automatic step(input string name, input logic rst_lvl, input logic v,
                        input int rs1, input int rs0, input int rd,
                        input logic rw, input logic mr, input logic br,
                        input logic frz, input logic fl,
                        input logic [3:0] e_ex, input logic [3:0] e_id, input logic e_st);
        exp_t    e;
        npc_op_e op;
        @(posedge clk);
        #1;
        op           = br ? NPC_BRANCH : NPC_PLUS4;
        rstn         = rst_lvl;
        id_valid     = v;
        id_rs        = {5'(rs1), 5'(rs0)};
        id_rd        = 5'(rd);
        id_regwrite  = rw;
        id_memread   = mr;
        id_is_branch = npc_needs_id_operands(op);
        pipe_freeze  = frz;
        flush_ex     = fl;
        e.name = name;
        e.ex   = e_ex;
        e.id   = e_id;
        e.st   = e_st;
        sb.push_back(e);
    endtask

    task automatic idle(input string name, input logic [3:0] e_ex);
        step(name, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_ex, 4'b0000, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if ({ex_fwd, id_fwd, hazard_stall} !== {e.ex, e.id, e.st}) begin
                    n_fail++;
                    $display("FAIL %s: got ex_fwd=%b id_fwd=%b stall=%b, expected ex_fwd=%b id_fwd=%b stall=%b",
                             e.name, ex_fwd, id_fwd, hazard_stall, e.ex, e.id, e.st);
                end else begin
                    $display("ok   %s: ex_fwd=%b id_fwd=%b stall=%b",
                             e.name, ex_fwd, id_fwd, hazard_stall);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        //   name             rst  v    rs1 rs0 rd  rw    mr    br    frz   fl    ex       id       st
        step("reset",         1'b0, 1'b1, 6, 6, 7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        idle("idle0", 4'b0000);
        // ALU to ALU forwarding from MEM
        step("add_x5",        1'b1, 1'b1, 2, 1, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        step("add_use_x5",    1'b1, 1'b1, 3, 5, 10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        idle("fwd_mem_x5", 4'b0001);
        idle("idle1", 4'b0000);
        // load-use: one stall, then both operands from WB
        step("lw_x6",         1'b1, 1'b1, 0, 1, 6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        step("load_use",      1'b1, 1'b1, 6, 6, 7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1);
        step("load_use_rel",  1'b1, 1'b1, 6, 6, 7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        idle("fwd_wb_load", 4'b1010);
        idle("idle2", 4'b0000);
        // same rd in MEM and WB: MEM wins
        step("add_x9a",       1'b1, 1'b1, 0, 0, 9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        step("add_x9b",       1'b1, 1'b1, 0, 0, 9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        step("use_x9",        1'b1, 1'b1, 9, 9, 11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        idle("nearest_x9", 4'b0101);
        idle("idle3", 4'b0000);
        // x0 destination and non-writing load never match
        step("add_x0",        1'b1, 1'b1, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        step("lw_norw_x12",   1'b1, 1'b1, 0, 0, 12, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        step("beq_x12_x0",    1'b1, 1'b1, 0, 12, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        idle("norw_no_fwd", 4'b0000);
        idle("idle4", 4'b0000);
        // branch on a fresh ALU result
        step("add_x8",        1'b1, 1'b1, 0, 0, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        step("beq_x8_stall",  1'b1, 1'b1, 0, 8, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1);
`ifdef FWD_ID_BRANCH_EN
        step("beq_x8_idfwd",  1'b1, 1'b1, 0, 8, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0);
        idle("beq_in_ex", 4'b0010);
`else
        step("beq_x8_hold",   1'b1, 1'b1, 0, 8, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1);
        step("beq_x8_go",     1'b1, 1'b1, 0, 8, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        idle("beq_in_ex", 4'b0000);
`endif
        idle("idle5", 4'b0000);
        idle("idle6", 4'b0000);
        // freeze holds EX; flush squashes the entering instruction
        step("add_x13",       1'b1, 1'b1, 0, 0, 13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        step("freeze",        1'b1, 1'b1, 0, 13, 14, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
        step("add_x14",       1'b1, 1'b1, 0, 13, 14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        idle("fwd_after_freeze", 4'b0001);
        step("flush_x15",     1'b1, 1'b1, 0, 0, 15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);
        step("use_x15",       1'b1, 1'b1, 0, 15, 16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        idle("flushed_no_fwd", 4'b0000);
        // reset asserted while a load-use stall is held
        step("lw_x6_again",   1'b1, 1'b1, 0, 0, 6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        step("stall_frozen",  1'b1, 1'b1, 6, 6, 7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1);
        step("rst_mid_stall", 1'b0, 1'b1, 6, 6, 7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        step("after_rst",     1'b1, 1'b1, 6, 6, 7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        idle("no_stale_load", 4'b0000);

        repeat (3) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
